fetch_sequencer: RTL and testbench

Owns the program counter, the instruction register and the five-phase one-hot phase sequencer of the 16-bit multi-cycle core. It fetches the instruction in phase P1 and presents `command` and `pc_plus_1` to decode and to the branch ALU for the rest of the instruction. At the end of P5 it consumes `PCSrc` and `jump` from the branch ALU to update the PC. It also handles run, halt and single-step control.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/edge_detect.sv | 22 ++
 rtl/fetch_sequencer.sv | 85 ++++++++
 tb/tb_fetch_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle core: datapath width and the
// one-hot phase encoding that every stage decodes.
package cpu_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [4:0] PH_HALT = 5'b00000;
  localparam logic [4:0] PH_IF   = 5'b00001;
  localparam logic [4:0] PH_ID   = 5'b00010;
  localparam logic [4:0] PH_EX   = 5'b00100;
  localparam logic [4:0] PH_MEM  = 5'b01000;
  localparam logic [4:0] PH_WB   = 5'b10000;

  typedef enum logic [2:0] {
    StHalt,
    StP1,
    StP2,
    StP3,
    StP4,
    StP5
  } phase_e;

  function automatic logic [4:0] phase_onehot(input phase_e st);
    logic [4:0] ph;
    ph = PH_HALT;
    unique case (st)
      StP1:    ph = PH_IF;
      StP2:    ph = PH_ID;
      StP3:    ph = PH_EX;
      StP4:    ph = PH_MEM;
      StP5:    ph = PH_WB;
      default: ph = PH_HALT;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector with synchronous reset; the input is registered
// every cycle so a held level produces a single pulse.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/fetch_sequencer.sv
// PC, instruction register and five-phase sequencer of the multi-cycle core,
// with run/halt/single-step control.
module fetch_sequencer #(
  parameter int unsigned           WIDTH    = cpu_pkg::WIDTH,
  parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
  input  logic             step,
  input  logic             halt_req,
  input  logic [WIDTH-1:0] imem_data,
  input  logic             PCSrc,
  input  logic [WIDTH-1:0] jump,
  output logic [4:0]       phasecounter,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_1,
  output logic [WIDTH-1:0] command,
  output logic             halted
);

  import cpu_pkg::*;

  phase_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus_1_q, pc_plus_1_d;
  logic [WIDTH-1:0] command_q, command_d;
  logic             exec_rise;

  edge_detect u_exec_edge (
    .clk_i  (clock),
    .rst_i  (reset),
    .d_i    (exec),
    .rise_o (exec_rise)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pc_plus_1_d = pc_plus_1_q;
    command_d   = command_q;
    unique case (state_q)
      StHalt: begin
        if (exec_rise) begin
          state_d = StP1;
        end
      end
      StP1: begin
        command_d   = imem_data;
        pc_plus_1_d = pc_q + WIDTH'(1);
        state_d     = StP2;
      end
      StP2: state_d = StP3;
      StP3: state_d = StP4;
      StP4: state_d = StP5;
      StP5: begin
        // Branch inputs are only trusted here; the PC update happens even when halting.
        pc_d    = PCSrc ? jump : pc_plus_1_q;
        state_d = (halt_req || step) ? StHalt : StP1;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StHalt;
      pc_q        <= RESET_PC;
      pc_plus_1_q <= '0;
      command_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_plus_1_q <= pc_plus_1_d;
      command_q   <= command_d;
    end
  end

  assign phasecounter = phase_onehot(state_q);
  assign halted       = (state_q == StHalt);
  assign pc           = pc_q;
  assign pc_plus_1    = pc_plus_1_q;
  assign command      = command_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer: each vector's expected post-edge state is
// queued when driven and compared after the edge; a short step-mode run follows.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset, exec, step, halt_req, PCSrc;
  logic [15:0] imem_data, jump;
  logic [4:0]  phasecounter;
  logic [15:0] pc, pc_plus_1, command;
  logic        halted;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  fetch_sequencer #(
    .WIDTH    (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .exec         (exec),
    .step         (step),
    .halt_req     (halt_req),
    .imem_data    (imem_data),
    .PCSrc        (PCSrc),
    .jump         (jump),
    .phasecounter (phasecounter),
    .pc           (pc),
    .pc_plus_1    (pc_plus_1),
    .command      (command),
    .halted       (halted)
  );

  typedef struct {
    logic        rst, ex, st, hr;
    logic [15:0] im;
    logic        ps;
    logic [15:0] jp;
    logic [4:0]  ph;
    logic [15:0] pc, ppc, cmd;
    logic        hl;
  } vec_t;

  typedef struct {
    int          idx;
    logic [4:0]  ph;
    logic [15:0] pc, ppc, cmd;
    logic        hl;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic add(input logic rst, ex, st, hr, input logic [15:0] im, input logic ps,
                     input logic [15:0] jp, input logic [4:0] ph,
                     input logic [15:0] epc, eppc, ecmd, input logic hl);
    vec_t v;
    v.rst = rst; v.ex = ex; v.st = st; v.hr = hr; v.im = im; v.ps = ps; v.jp = jp;
    v.ph = ph; v.pc = epc; v.ppc = eppc; v.cmd = ecmd; v.hl = hl;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, got, want);
    end
  endtask

  initial begin
    exp_t e;
    int   cycles;

    reset = 1'b1; exec = 1'b0; step = 1'b0; halt_req = 1'b0;
    imem_data = '0; PCSrc = 1'b0; jump = '0;

    //  rst ex st hr  im        ps jp          ph     pc        ppc       cmd       hl
    add(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0000, 16'h0000, 16'h0000, 1);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0000, 16'h0000, 16'h0000, 1);
    add(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 5'h01, 16'h0000, 16'h0000, 16'h0000, 0);
    add(0, 1, 0, 0, 16'h8000, 0, 16'h0000, 5'h02, 16'h0000, 16'h0001, 16'h8000, 0);
    // Branch and halt inputs outside P5 must be ignored.
    add(0, 0, 0, 0, 16'h0000, 1, 16'h0040, 5'h04, 16'h0000, 16'h0001, 16'h8000, 0);
    add(0, 0, 0, 1, 16'h0000, 1, 16'h0040, 5'h08, 16'h0000, 16'h0001, 16'h8000, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'h0000, 16'h0001, 16'h8000, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0040, 5'h01, 16'h0001, 16'h0001, 16'h8000, 0);
    add(0, 0, 0, 0, 16'h1234, 0, 16'h0000, 5'h02, 16'h0001, 16'h0002, 16'h1234, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'h0001, 16'h0002, 16'h1234, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h08, 16'h0001, 16'h0002, 16'h1234, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'h0001, 16'h0002, 16'h1234, 0);
    add(0, 0, 0, 0, 16'h0000, 1, 16'h0040, 5'h01, 16'h0040, 16'h0002, 16'h1234, 0);
    add(0, 0, 0, 0, 16'hABCD, 0, 16'h0000, 5'h02, 16'h0040, 16'h0041, 16'hABCD, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'h0040, 16'h0041, 16'hABCD, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h08, 16'h0040, 16'h0041, 16'hABCD, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'h0040, 16'h0041, 16'hABCD, 0);
    add(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 5'h01, 16'hFFFF, 16'h0041, 16'hABCD, 0);
    add(0, 0, 0, 0, 16'h5555, 0, 16'h0000, 5'h02, 16'hFFFF, 16'h0000, 16'h5555, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'hFFFF, 16'h0000, 16'h5555, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h08, 16'hFFFF, 16'h0000, 16'h5555, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'hFFFF, 16'h0000, 16'h5555, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h01, 16'h0000, 16'h0000, 16'h5555, 0);
    add(0, 0, 0, 0, 16'h7777, 0, 16'h0000, 5'h02, 16'h0000, 16'h0001, 16'h7777, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'h0000, 16'h0001, 16'h7777, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h08, 16'h0000, 16'h0001, 16'h7777, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'h0000, 16'h0001, 16'h7777, 0);
    // HLT together with a taken branch: PC still updates, then halt; held exec must not restart.
    add(0, 1, 0, 1, 16'h0000, 1, 16'h0010, 5'h00, 16'h0010, 16'h0001, 16'h7777, 1);
    add(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0010, 16'h0001, 16'h7777, 1);
    add(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0010, 16'h0001, 16'h7777, 1);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0010, 16'h0001, 16'h7777, 1);
    add(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 5'h01, 16'h0010, 16'h0001, 16'h7777, 0);
    add(0, 0, 0, 0, 16'h4321, 0, 16'h0000, 5'h02, 16'h0010, 16'h0011, 16'h4321, 0);
    add(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'h0010, 16'h0011, 16'h4321, 0);
    // Reset in P3 abandons the instruction.
    add(1, 0, 0, 0, 16'h0000, 1, 16'h0099, 5'h00, 16'h0000, 16'h0000, 16'h0000, 1);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0000, 16'h0000, 16'h0000, 1);
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 5'h01, 16'h0000, 16'h0000, 16'h0000, 0);
    add(0, 0, 1, 0, 16'h0100, 0, 16'h0000, 5'h02, 16'h0000, 16'h0001, 16'h0100, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'h0000, 16'h0001, 16'h0100, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h08, 16'h0000, 16'h0001, 16'h0100, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'h0000, 16'h0001, 16'h0100, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0001, 16'h0001, 16'h0100, 1);
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 5'h01, 16'h0001, 16'h0001, 16'h0100, 0);
    add(0, 0, 1, 0, 16'h0200, 0, 16'h0000, 5'h02, 16'h0001, 16'h0002, 16'h0200, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'h0001, 16'h0002, 16'h0200, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h08, 16'h0001, 16'h0002, 16'h0200, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'h0001, 16'h0002, 16'h0200, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0002, 16'h0002, 16'h0200, 1);
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 5'h01, 16'h0002, 16'h0002, 16'h0200, 0);
    add(0, 0, 1, 0, 16'h0300, 0, 16'h0000, 5'h02, 16'h0002, 16'h0003, 16'h0300, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h04, 16'h0002, 16'h0003, 16'h0300, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h08, 16'h0002, 16'h0003, 16'h0300, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h10, 16'h0002, 16'h0003, 16'h0300, 0);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 5'h00, 16'h0003, 16'h0003, 16'h0300, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; exec = tbl[i].ex; step = tbl[i].st; halt_req = tbl[i].hr;
      imem_data = tbl[i].im; PCSrc = tbl[i].ps; jump = tbl[i].jp;
      e.idx = i; e.ph = tbl[i].ph; e.pc = tbl[i].pc; e.ppc = tbl[i].ppc;
      e.cmd = tbl[i].cmd; e.hl = tbl[i].hl;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk("phasecounter", e.idx, {11'b0, phasecounter}, {11'b0, e.ph});
      chk("pc", e.idx, pc, e.pc);
      chk("pc_plus_1", e.idx, pc_plus_1, e.ppc);
      chk("command", e.idx, command, e.cmd);
      chk("halted", e.idx, {15'b0, halted}, {15'b0, e.hl});
    end

    // Step mode: one exec edge runs exactly one five-phase instruction from pc 0003.
    reset = 1'b0; step = 1'b1; halt_req = 1'b0; PCSrc = 1'b0; imem_data = '0;
    exec = 1'b1;
    cycles = 0;
    do begin
      @(posedge clock);
      #1;
      cycles++;
    end while (phasecounter != 5'h01 && cycles < 4);
    chk("step_start_phase", 0, {11'b0, phasecounter}, 16'h0001);
    chk("step_start_pc", 0, pc, 16'h0003);
    cycles = 0;
    while (!halted && cycles < 20) begin
      @(posedge clock);
      #1;
      cycles++;
    end
    chk("step_cycles", 0, 16'(cycles), 16'd5);
    chk("step_end_pc", 0, pc, 16'h0004);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      chk("held_exec_halted", k, {15'b0, halted}, 16'h0001);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
